// File: rtl/fft_iter_pkg.sv
// Shared definitions for the iterative FFT layer sequencer: state encoding
// and the slot-count helpers derived from the butterfly counter width.
package fft_iter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        LAYER_SW = 2'd2,
        FIN      = 2'd3
    } seq_state_t;

    // Butterflies issued per layer (N/2).
    function automatic int nbut(input int butt_wl);
        return 1 << butt_wl;
    endfunction

    // Slots per layer: every butterfly plus the drain slots that let the
    // last results reach the work RAM before the layer switch.
    function automatic int slots(input int butt_wl, input int pipe_slots);
        return nbut(butt_wl) + pipe_slots;
    endfunction

endpackage

// File: rtl/fft_slot_timer.sv
// Phase/slot counter pair for the layer sequencer. Phase walks through one
// butterfly slot, slot walks through one layer; both freeze while en is low.
module fft_slot_timer #(
    parameter int PhWL       = 3,
    parameter int SlotWL     = 5,
    parameter int BUT_PERIOD = 4,
    parameter int SLOTS      = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              run,
    output logic [PhWL-1:0]   phase,
    output logic [SlotWL-1:0] slot,
    output logic              phase_last,
    output logic              slot_last
);

    assign phase_last = (phase == PhWL'(BUT_PERIOD - 1));
    assign slot_last  = (slot == SlotWL'(SLOTS - 1));

    // Advance phase every running cycle; step slot when the phase wraps, and
    // wrap slot after the last slot so a fresh layer starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            slot  <= '0;
        end else if (en) begin
            if (clr) begin
                phase <= '0;
                slot  <= '0;
            end else if (run) begin
                if (phase_last) begin
                    phase <= '0;
                    slot  <= slot_last ? '0 : slot + SlotWL'(1);
                end else begin
                    phase <= phase + PhWL'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fft_iter_layer_sequencer.sv
// Cycle-level scheduler for the in-place iterative radix-2 FFT core. Issues
// one butterfly per slot, drains the butterfly pipeline at the end of each
// layer, then switches layer; reports BUSY/DONE and honours EN and ABORT.
module fft_iter_layer_sequencer
    import fft_iter_pkg::*;
#(
    parameter int LAYERS     = 5,
    parameter int LayWL      = 4,
    parameter int ButtWL     = 4,
    parameter int BUT_PERIOD = 4,
    parameter int PIPE_SLOTS = 2,
    parameter int PhWL       = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             START,
    input  logic             ABORT,
    output logic             BUT_STROB,
    output logic             ADDR_EN,
    output logic             LAY_EN,
    output logic             Wr,
    output logic             FIRST,
    output logic             BUSY,
    output logic             DONE,
    output logic [LayWL-1:0] LAYER
);

    localparam int N_BUT   = nbut(ButtWL);
    localparam int N_SLOTS = slots(ButtWL, PIPE_SLOTS);
    localparam int SlotWL  = $clog2(N_SLOTS);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [LayWL-1:0]  layer;
    logic [PhWL-1:0]   phase;
    logic [SlotWL-1:0] slot;
    logic              phase_last;
    logic              slot_last;
    logic              timer_clr;
    logic              timer_run;
    logic              layer_clr;
    logic              layer_inc;

    fft_slot_timer #(
        .PhWL       (PhWL),
        .SlotWL     (SlotWL),
        .BUT_PERIOD (BUT_PERIOD),
        .SLOTS      (N_SLOTS)
    ) u_timer (
        .clk        (CLK),
        .rst_n      (RST),
        .en         (EN),
        .clr        (timer_clr),
        .run        (timer_run),
        .phase      (phase),
        .slot       (slot),
        .phase_last (phase_last),
        .slot_last  (slot_last)
    );

    // State register; EN low is folded into the next-state logic as a hold.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Layer index: cleared on a new transform or abort, kept after FIN so the
    // host can still read the final layer while idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            layer <= '0;
        end else if (layer_clr) begin
            layer <= '0;
        end else if (layer_inc) begin
            layer <= layer + LayWL'(1);
        end
    end

    // Next-state and strobe decode. ABORT outranks everything; with EN low the
    // state holds and every pulse is suppressed, so the same cycle replays on
    // resume.
    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        timer_run = 1'b0;
        layer_clr = 1'b0;
        layer_inc = 1'b0;
        BUT_STROB = 1'b0;
        ADDR_EN   = 1'b0;
        LAY_EN    = 1'b0;
        Wr        = 1'b0;
        DONE      = 1'b0;
        if (EN && ABORT) begin
            state_d   = IDLE;
            timer_clr = 1'b1;
            layer_clr = 1'b1;
        end else if (EN) begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        state_d   = RUN;
                        timer_clr = 1'b1;
                        layer_clr = 1'b1;
                    end
                end
                RUN: begin
                    timer_run = 1'b1;
                    // Phase 0 writes back the butterfly issued PIPE_SLOTS ago.
                    Wr        = (phase == '0) && (slot >= SlotWL'(PIPE_SLOTS));
                    BUT_STROB = phase_last;
                    // Drain slots advance the pipeline but issue no new address.
                    ADDR_EN   = phase_last && (slot < SlotWL'(N_BUT));
                    if (phase_last && slot_last) begin
                        state_d = (layer < LayWL'(LAYERS - 1)) ? LAYER_SW : FIN;
                    end
                end
                LAYER_SW: begin
                    LAY_EN    = 1'b1;
                    layer_inc = 1'b1;
                    timer_clr = 1'b1;
                    state_d   = RUN;
                end
                FIN: begin
                    DONE    = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign FIRST = (state_q == RUN) && (layer == '0);
    assign BUSY  = (state_q != IDLE);
    assign LAYER = layer;

endmodule

// File: doc/fft_iter_layer_sequencer.md
Name: fft_iter_layer_sequencer

Overview:
- Cycle-level scheduler for the in-place iterative radix-2 FFT core.
- Consumes START and generates the datapath strobes:
  - BUT_STROB: butterfly pipeline advance
  - ADDR_EN: butterfly/twiddle address generator step
  - LAY_EN: layer switch
  - WR: work RAM write
  - FIRST: source = input RAM
- Issues one butterfly per BUT_PERIOD-cycle slot and drains the butterfly pipeline before each layer switch, so the next layer never reads stale data.
- Reports BUSY and DONE to the host, and honours EN stall and ABORT.

Parameters:
- LAYERS, 5, FFT layers (log2 N).
- LayWL, 4, layer counter width; must satisfy 2^LayWL > LAYERS.
- ButtWL, 4, butterfly counter width; butterflies per layer = 2^ButtWL = N/2.
- BUT_PERIOD, 4, cycles per butterfly slot; minimum 3.
- PIPE_SLOTS, 2, slots between a butterfly's issue and its write-back (operand register + butterfly latency).
- PhWL, 3, phase counter width; must satisfy 2^PhWL >= BUT_PERIOD.

Ports:
- CLK, in, 1: clock, rising edge.
- RST, in, 1: asynchronous, active-low reset.
- EN, in, 1: global enable; low freezes all state and forces all pulse outputs to 0.
- START, in, 1: begin transform; sampled only in IDLE.
- ABORT, in, 1: synchronous abort to IDLE; no DONE is generated.
- BUT_STROB, out, 1: one-cycle pulse per slot.
- ADDR_EN, out, 1: one-cycle pulse; advances the address generators.
- LAY_EN, out, 1: one-cycle pulse between layers.
- Wr, out, 1: work RAM write enable; muxes write addresses onto the RAM ports.
- FIRST, out, 1: high throughout layer 0.
- BUSY, out, 1: high in any state other than IDLE.
- DONE, out, 1: one-cycle pulse at transform completion.
- LAYER, out, LayWL: current layer index.

Behaviour:
- Reset (RST=0, asynchronous):
  - state = IDLE, all counters = 0, all outputs = 0.
  - Mid-transform reset drops the operation with no DONE.
- States: IDLE, RUN, LAYER_SW, FIN.
- IDLE:
  - START=1 and EN=1 → RUN, with layer=0, slot=0, phase=0.
  - START while BUSY is ignored.
- RUN: phase counts 0..BUT_PERIOD-1; slot counts 0..SLOTS-1, where SLOTS = 2^ButtWL + PIPE_SLOTS.
  - phase 0: Wr=1 iff slot >= PIPE_SLOTS, writing the result of butterfly slot-PIPE_SLOTS. This is the only cycle Wr is high.
  - phase 1..BUT_PERIOD-2: read cycles; Wr=0, so read addresses reach the RAMs.
  - phase BUT_PERIOD-1:
    - BUT_STROB=1 in every slot, including drain slots.
    - ADDR_EN=1 iff slot < 2^ButtWL.
- End of last slot (slot=SLOTS-1, phase=BUT_PERIOD-1):
  - If layer < LAYERS-1 → LAYER_SW.
  - Otherwise → FIN.
- LAYER_SW (one cycle):
  - LAY_EN=1; layer increments.
  - slot and phase clear → RUN.
- FIN (one cycle): DONE=1 → IDLE.
- FIRST: equals (layer==0) while in RUN; 0 elsewhere.
- LAYER: holds its last value in IDLE until the next START clears it.
- EN=0:
  - Hold state, phase, slot and layer.
  - Force BUT_STROB, ADDR_EN, LAY_EN, Wr and DONE to 0.
  - On resume, the same cycle's outputs are produced; no event is lost or duplicated.
- ABORT=1 (when EN=1): → IDLE next cycle, counters cleared, no DONE. ABORT has priority over all other transitions.
- Simultaneous START and ABORT in IDLE: ABORT wins; remain in IDLE.
- Latency from the START cycle t0 to the DONE cycle: LAYERS·SLOTS·BUT_PERIOD + (LAYERS-1) + 1 cycles.

Decomposition:
- Shared package fft_iter_pkg holds:
  - state encoding (IDLE=0, RUN=1, LAYER_SW=2, FIN=3)
  - helper constants NBUT = 2^ButtWL and SLOTS = NBUT + PIPE_SLOTS
- Sub-module fft_slot_timer: phase/slot counter pair with EN stall and terminal-count flags. The FSM and strobe decode stay in the top.

Test Plan:
- LAYERS=3, ButtWL=2, BUT_PERIOD=4, PIPE_SLOTS=2; START at t0:
  - BUSY=1 from t0+1; DONE pulses exactly at t0+75.
  - Totals: BUT_STROB=18, ADDR_EN=12, Wr=12, LAY_EN=2 (at t0+25 and t0+50).
  - FIRST high over t0+1..t0+24.
- Per slot, same configuration: Wr only at phase 0 of slots 2..5; BUT_STROB and ADDR_EN coincident only at phase 3 of slots 0..3; slots 4..5 show BUT_STROB with ADDR_EN=0.
- EN held low for 7 cycles mid-layer 1: all pulses stay 0 while EN is low; DONE moves to t0+82; pulse totals unchanged.
- START re-asserted at t0+30 while BUSY: no effect; LAYER sequence 0,1,2; a single DONE.
- ABORT at t0+40: BUSY=0 at t0+41 and no DONE. A new START at t0+45 gives DONE at t0+120.
- RST driven low at t0+10 asynchronously: all outputs 0 in the same cycle, state IDLE; after release, START behaves as in the first scenario.
